uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares one `uart_transmitter` between `NREQ` byte producers with a round-robin scheduler. It sits between the requesters (echo path, status reporter, debug dump, ...) and the transmitter's `rx_new_byte`/`rx_byte`/`tx_ready` ports. It issues exactly one byte per transmitter-ready window and acknowledges the winning requester. An optional lock lets a requester keep the grant for a multi-byte message.

## Interface
- `NREQ`, default 4: number of requesters, legal range 2..8.
- `IDW`, default 2: width of `grant_id`; must equal ceil(log2(`NREQ`)).

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  bit i high means requester i has a byte pending.
- `req_byte`  in  8*NREQ  byte of requester i on bits [8i+7:8i].
- `req_lock`  in  NREQ  bit i high means requester i asks to keep the grant after this byte. Ignored unless `UART_ARB_LOCK_EN` is defined.
- `req_ack`  out  NREQ  one-cycle pulse on bit i when requester i's byte is taken.
- `tx_ready`  in  1  from the transmitter; high means it can accept a byte.
- `tx_new_byte`  out  1  one-cycle strobe to the transmitter's `rx_new_byte`.
- `tx_byte`  out  8  byte to the transmitter's `rx_byte`; valid while `tx_new_byte` is high.
- `grant_id`  out  IDW  index of the requester most recently served.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, GUARD, WAIT. Reset enters IDLE.
- IDLE:
  - Acts only when `tx_ready`=1 and the eligible-request vector is nonzero.
  - Winner w is the first set bit scanning from `last`+1 upward, modulo `NREQ`.
  - On the same edge it registers `tx_byte`<=byte w, `tx_new_byte`<=1, `req_ack[w]`<=1, `grant_id`<=w and `last`<=w, then goes to GUARD.
- GUARD: lasts exactly one cycle.
  - `tx_new_byte` and `req_ack` return to 0.
  - `tx_ready` is ignored, to cover the transmitter's one-cycle drop latency.
  - Next state is WAIT.
- WAIT: stays until `tx_ready`=1, then goes to IDLE.
  - WAIT does not arbitrate; the next issue can happen at the earliest on the IDLE cycle that follows.
- Eligible vector:
  - Without the lock feature, or with no lock held: `req_valid`.
  - With a lock held by requester L: `req_valid` AND one-hot(L).
- Requester rules:
  - Hold `req_valid` and the byte stable until `req_ack` is seen.
  - Deassert `req_valid`, or present the next byte, in the cycle after the ack.
  - Dropping `req_valid` before the ack withdraws the request; no byte is sent.
- `last` resets to `NREQ`-1, so requester 0 wins first.
- Requester indices at or above `NREQ` do not exist; `grant_id` never exceeds `NREQ`-1.

## Timing
- Reset values: `tx_new_byte`=0, `tx_byte`=8'h00, `req_ack`=0, `grant_id`=0, `busy`=0, state IDLE, lock cleared.
- Latency: `req_valid` sampled high in IDLE with `tx_ready`=1 gives `tx_new_byte` and `req_ack` high in the next cycle.
- Minimum spacing between strobes is 3 cycles, reached when `tx_ready` is already high on the first WAIT cycle.
- Simultaneous requests resolve by round-robin only; there is no fixed priority.
- A request arriving in the same cycle as `tx_ready` rising in WAIT is served on the following IDLE cycle.
- Reset mid-operation (`rst_n` low in any state):
  - All outputs clear immediately, because the reset is asynchronous.
  - An in-flight strobe is cut, and any lock is dropped.
  - A byte the transmitter already accepted is not tracked or re-sent.
- `tx_ready` low in IDLE: no issue and no ack; requests stay pending.

## Configuration
- `UART_ARB_LOCK_EN` defined:
  - In IDLE, when issuing for w with `req_lock[w]`=1, the arbiter sets lock holder L=w.
  - While the lock is held, only L is eligible. If `req_valid[L]`=0, the arbiter idles; no other requester is served.
  - The lock clears on the issue of an L byte with `req_lock[L]`=0, or when `req_valid[L]`=0 and `req_lock[L]`=0 in IDLE.
- `UART_ARB_LOCK_EN` undefined:
  - The `req_lock` port remains but is ignored; no lock register exists.
  - Plain round-robin applies on every byte.

## Test plan
- Reset, then `req_valid`=4'b0001 with byte 8'h41 and `tx_ready`=1 -> next cycle `tx_new_byte`=1, `tx_byte`=8'h41, `req_ack`=4'b0001, `grant_id`=0; `busy` high until `tx_ready` is seen high again in WAIT.
- `req_valid`=4'b1111 held continuously; transmitter model drops `tx_ready` for 10 cycles per byte -> acks in order 0,1,2,3,0,1; each requester served every 4th byte.
- `tx_ready`=0 in IDLE with `req_valid`=4'b0100 -> no strobe. Raise `tx_ready` -> strobe one cycle later with requester 2's byte.
- `rst_n` pulsed low during WAIT after a strobe -> all outputs 0 asynchronously; after release, requester 0 wins the first contention against requester 3.
- `UART_ARB_LOCK_EN` defined: requester 1 sends 3 bytes with `req_lock`=1,1,0 while requester 2 is also requesting -> bytes go out as 1,1,1, then 2.
- `UART_ARB_LOCK_EN` undefined, same stimulus -> bytes go out as 1,2,1,2,1.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds one uart_transmitter from NREQ byte producers.
// Optional message lock (a requester keeps the grant) is enabled by defining UART_ARB_LOCK_EN.
module uart_tx_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_byte,
  input  logic [NREQ-1:0]   req_lock,
  output logic [NREQ-1:0]   req_ack,
  input  logic              tx_ready,
  output logic              tx_new_byte,
  output logic [7:0]        tx_byte,
  output logic [IDW-1:0]    grant_id,
  output logic              busy
);

  // Handshake: a requester holds req_valid and its byte stable until it sees
  // its req_ack pulse; the byte is taken on the edge that raises req_ack.
  // tx_new_byte is a one-cycle strobe issued only while tx_ready was high in IDLE.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUARD = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [IDW-1:0]  grant_d;
  logic [7:0]      tx_byte_d;
  logic            tx_new_byte_d;
  logic [NREQ-1:0] req_ack_d;
  logic [NREQ-1:0] eligible;
  logic            win_found;
  logic [IDW-1:0]  win_id;

`ifdef UART_ARB_LOCK_EN
  logic            lock_q, lock_d;
  logic [IDW-1:0]  lock_id_q, lock_id_d;
  logic [NREQ-1:0] lock_mask;

  assign lock_mask = {{(NREQ-1){1'b0}}, 1'b1} << lock_id_q;
  assign eligible  = lock_q ? (req_valid & lock_mask) : req_valid;
`else
  logic unused_req_lock;

  assign unused_req_lock = ^req_lock;
  assign eligible        = req_valid;
`endif

  assign busy = (state_q != IDLE);

  // Scan starts one past the previous winner so every requester gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!win_found && eligible[(int'(last_q) + k) % NREQ]) begin
        win_found = 1'b1;
        win_id    = IDW'((int'(last_q) + k) % NREQ);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    grant_d       = grant_id;
    tx_byte_d     = tx_byte;
    tx_new_byte_d = 1'b0;
    req_ack_d     = '0;
`ifdef UART_ARB_LOCK_EN
    lock_d        = lock_q;
    lock_id_d     = lock_id_q;
`endif
    case (state_q)
      IDLE: begin
        if (tx_ready && win_found) begin
          state_d           = GUARD;
          last_d            = win_id;
          grant_d           = win_id;
          tx_byte_d         = req_byte[8*int'(win_id) +: 8];
          tx_new_byte_d     = 1'b1;
          req_ack_d[win_id] = 1'b1;
`ifdef UART_ARB_LOCK_EN
          lock_d            = req_lock[win_id];
          lock_id_d         = win_id;
`endif
        end
`ifdef UART_ARB_LOCK_EN
        else if (lock_q && !req_valid[lock_id_q] && !req_lock[lock_id_q]) begin
          lock_d = 1'b0;
        end
`endif
      end
      // The transmitter lowers tx_ready one cycle after the strobe; skip that cycle.
      GUARD: state_d = WAIT;
      WAIT: begin
        if (tx_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= IDW'(NREQ - 1);
      grant_id    <= '0;
      tx_byte     <= 8'h00;
      tx_new_byte <= 1'b0;
      req_ack     <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      grant_id    <= grant_d;
      tx_byte     <= tx_byte_d;
      tx_new_byte <= tx_new_byte_d;
      req_ack     <= req_ack_d;
    end
  end

`ifdef UART_ARB_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester sources, a tx_ready drop model and an
// expected-byte queue checked on every tx_new_byte strobe.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_byte;
  logic [NREQ-1:0]   req_lock;
  logic [NREQ-1:0]   req_ack;
  logic              tx_ready;
  logic              tx_new_byte;
  logic [7:0]        tx_byte;
  logic [IDW-1:0]    grant_id;
  logic              busy;

  uart_tx_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_byte    (req_byte),
    .req_lock    (req_lock),
    .req_ack     (req_ack),
    .tx_ready    (tx_ready),
    .tx_new_byte (tx_new_byte),
    .tx_byte     (tx_byte),
    .grant_id    (grant_id),
    .busy        (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Scoreboard entry: {1'b0, requester id, byte}
  logic [10:0] exp_q[$];

  logic [7:0] src_byte[NREQ][8];
  logic       src_lock[NREQ][8];
  int         src_cnt[NREQ];
  int         src_idx[NREQ];
  int         ready_cnt;

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_sources();
    for (int i = 0; i < NREQ; i++) begin
      src_cnt[i] = 0;
      src_idx[i] = 0;
    end
  endtask

  task automatic load(input int id, input logic [7:0] b, input logic lk);
    src_byte[id][src_cnt[id]] = b;
    src_lock[id][src_cnt[id]] = lk;
    src_cnt[id]++;
  endtask

  task automatic expect_tx(input int id, input logic [7:0] b);
    exp_q.push_back({1'b0, id[2:0], b});
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NREQ; i++) begin
      if (src_idx[i] < src_cnt[i]) begin
        req_valid[i]       = 1'b1;
        req_byte[8*i +: 8] = src_byte[i][src_idx[i]];
        req_lock[i]        = src_lock[i][src_idx[i]];
      end else begin
        req_valid[i]       = 1'b0;
        req_byte[8*i +: 8] = 8'h00;
        req_lock[i]        = 1'b0;
      end
    end
  endtask

  // Runs until the scoreboard drains. drop>0: tx_ready low for drop cycles after
  // each strobe; drop==0: tx_ready held high and strobe spacing must be 3.
  task automatic run_traffic(input int drop, input int budget);
    logic [10:0] e;
    int cyc;
    int last_strobe;
    cyc         = 0;
    last_strobe = -1;
    tx_ready    = 1'b1;
    ready_cnt   = 0;
    drive_inputs();
    while (exp_q.size() > 0 && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      if (tx_new_byte) begin
        e = exp_q.pop_front();
        checks++;
        if ({1'b0, grant_id, tx_byte} !== e || req_ack !== (4'b0001 << e[10:8])) begin
          failures++;
          $display("FAIL strobe: got id=%0d byte=%h ack=%b, expected id=%0d byte=%h",
                   grant_id, tx_byte, req_ack, e[10:8], e[7:0]);
        end
        if (drop == 0 && last_strobe >= 0) begin
          checks++;
          if (cyc - last_strobe !== 3) begin
            failures++;
            $display("FAIL spacing: got %0d cycles, expected 3", cyc - last_strobe);
          end
        end
        last_strobe = cyc;
        for (int i = 0; i < NREQ; i++)
          if (req_ack[i] && src_idx[i] < src_cnt[i]) src_idx[i]++;
        if (drop > 0) begin
          tx_ready  = 1'b0;
          ready_cnt = drop;
        end
      end else begin
        checks++;
        if (req_ack !== '0) begin
          failures++;
          $display("FAIL ack_no_strobe: got ack=%b, expected 0000", req_ack);
        end
        if (ready_cnt > 0) begin
          ready_cnt--;
          if (ready_cnt == 0) tx_ready = 1'b1;
        end
      end
      drive_inputs();
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL timeout: %0d bytes still expected, expected 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  // Withdraw all requests and bring the arbiter back to IDLE.
  task automatic settle();
    int n;
    for (int i = 0; i < NREQ; i++) src_idx[i] = src_cnt[i];
    drive_inputs();
    tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    tx_ready = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (busy && n < 20);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL settle: busy=%b, expected 0", busy);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({tx_new_byte, tx_byte, req_ack, grant_id, busy} !== '0) begin
      failures++;
      $display("FAIL reset_values: got strobe=%b byte=%h ack=%b id=%0d busy=%b, expected all 0",
               tx_new_byte, tx_byte, req_ack, grant_id, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || tx_new_byte !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: busy=%b strobe=%b, expected 0 0", busy, tx_new_byte);
    end
  endtask

  task automatic test_first_byte();
    clear_sources();
    load(0, 8'h41, 1'b0);
    tx_ready = 1'b1;
    drive_inputs();
    @(posedge clk); #1;
    checks++;
    if (tx_new_byte !== 1'b1 || tx_byte !== 8'h41 || req_ack !== 4'b0001 ||
        grant_id !== 2'd0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL first_byte: got strobe=%b byte=%h ack=%b id=%0d busy=%b, expected 1 41 0001 0 1",
               tx_new_byte, tx_byte, req_ack, grant_id, busy);
    end
    src_idx[0] = 1;
    drive_inputs();
    tx_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b1 || tx_new_byte !== 1'b0 || req_ack !== '0) begin
        failures++;
        $display("FAIL busy_hold: cycle %0d busy=%b strobe=%b ack=%b, expected 1 0 0000",
                 c, busy, tx_new_byte, req_ack);
      end
    end
    tx_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_release: busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_ready_low();
    clear_sources();
    load(2, 8'h52, 1'b0);
    tx_ready = 1'b0;
    drive_inputs();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (tx_new_byte !== 1'b0 || req_ack !== '0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL ready_low: strobe=%b ack=%b busy=%b, expected 0 0000 0",
                 tx_new_byte, req_ack, busy);
      end
    end
    tx_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (tx_new_byte !== 1'b1 || tx_byte !== 8'h52 || grant_id !== 2'd2 || req_ack !== 4'b0100) begin
      failures++;
      $display("FAIL ready_rise: strobe=%b byte=%h id=%0d ack=%b, expected 1 52 2 0100",
               tx_new_byte, tx_byte, grant_id, req_ack);
    end
    settle();
  endtask

  task automatic test_mid_reset();
    clear_sources();
    load(3, 8'h33, 1'b0);
    tx_ready = 1'b1;
    drive_inputs();
    @(posedge clk); #1;
    checks++;
    if (tx_new_byte !== 1'b1 || grant_id !== 2'd3 || tx_byte !== 8'h33) begin
      failures++;
      $display("FAIL pre_reset_strobe: strobe=%b id=%0d byte=%h, expected 1 3 33",
               tx_new_byte, grant_id, tx_byte);
    end
    src_idx[3] = 1;
    drive_inputs();
    tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({tx_new_byte, tx_byte, req_ack, grant_id, busy} !== '0) begin
      failures++;
      $display("FAIL async_reset: got strobe=%b byte=%h ack=%b id=%0d busy=%b, expected all 0",
               tx_new_byte, tx_byte, req_ack, grant_id, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_sources();
    load(0, 8'h30, 1'b0);
    load(3, 8'h3C, 1'b0);
    expect_tx(0, 8'h30);
    expect_tx(3, 8'h3C);
    run_traffic(3, 100);
    settle();
  endtask

  task automatic test_round_robin();
    clear_sources();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NREQ; i++)
        load(i, 8'($urandom_range(0, 255)), 1'b0);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NREQ; i++)
        expect_tx(i, src_byte[i][k]);
    run_traffic(10, 300);
    settle();
  endtask

  task automatic test_back_to_back();
    clear_sources();
    for (int i = 0; i < 3; i++) begin
      load(i, 8'($urandom_range(0, 255)), 1'b0);
      expect_tx(i, src_byte[i][0]);
    end
    run_traffic(0, 60);
    settle();
  endtask

  task automatic test_lock();
    apply_reset();
    clear_sources();
    load(1, 8'hA1, 1'b1);
    load(1, 8'hA2, 1'b1);
    load(1, 8'hA3, 1'b0);
    load(2, 8'hB1, 1'b0);
    load(2, 8'hB2, 1'b0);
`ifdef UART_ARB_LOCK_EN
    expect_tx(1, 8'hA1);
    expect_tx(1, 8'hA2);
    expect_tx(1, 8'hA3);
    expect_tx(2, 8'hB1);
    expect_tx(2, 8'hB2);
`else
    expect_tx(1, 8'hA1);
    expect_tx(2, 8'hB1);
    expect_tx(1, 8'hA2);
    expect_tx(2, 8'hB2);
    expect_tx(1, 8'hA3);
`endif
    run_traffic(2, 200);
    settle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n     = 1'b0;
    tx_ready  = 1'b0;
    req_valid = '0;
    req_byte  = '0;
    req_lock  = '0;
    ready_cnt = 0;
    clear_sources();
    test_reset();
    test_first_byte();
    test_ready_low();
    test_mid_reset();
    test_round_robin();
    test_back_to_back();
    test_lock();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
